// File: rtl/kanagawa_race_monitor_pkg.sv
// Shared types for the race rate monitor: FSM encoding, counter widths and
// the report layout handed to the one-entry output register.
package kanagawa_race_monitor_pkg;

  localparam int WIN_IDX_W  = 16;
  localparam int DROP_CNT_W = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } mon_state_e;

  // Layout at the default widths; the top re-declares it at its own widths.
  typedef struct packed {
    logic [15:0]          delta;
    logic [31:0]          total;
    logic [WIN_IDX_W-1:0] window_idx;
  } race_report_t;

endpackage

// File: rtl/kanagawa_race_report_reg.sv
// One-entry valid/ready holding register for window reports. A load that
// finds the slot occupied and not draining is refused and flagged as dropped.
module kanagawa_race_report_reg
  import kanagawa_race_monitor_pkg::*;
#(
  parameter type rpt_t = race_report_t
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  rpt_t rpt_i,
  input  logic ready_i,
  output logic valid_o,
  output rpt_t rpt_o,
  output logic dropped_o
);

  logic valid_q, valid_d;
  rpt_t rpt_q, rpt_d;
  logic accept;

  always_comb begin
    accept    = load_i && (!valid_q || ready_i);
    dropped_o = load_i && !accept;
    valid_d   = valid_q;
    rpt_d     = rpt_q;
    if (accept) begin
      valid_d = 1'b1;
      rpt_d   = rpt_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rpt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rpt_q   <= rpt_d;
    end
  end

  assign valid_o = valid_q;
  assign rpt_o   = rpt_q;

endmodule

// File: rtl/kanagawa_race_rate_monitor.sv
// Windowed rate monitor: samples the running race total once per window and
// reports the saturated delta, raw total and window index, with a sticky alarm.
module kanagawa_race_rate_monitor
  import kanagawa_race_monitor_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32,
  parameter int DELTA_WIDTH   = 16,
  parameter int WINDOW_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COUNTER_WIDTH-1:0] race_count_in,
  input  logic [DELTA_WIDTH-1:0]   threshold_in,
  input  logic                     alarm_clear_in,
  output logic                     report_valid_out,
  input  logic                     report_ready_in,
  output logic [DELTA_WIDTH-1:0]   report_delta_out,
  output logic [COUNTER_WIDTH-1:0] report_total_out,
  output logic [WIN_IDX_W-1:0]     report_window_idx_out,
  output logic                     alarm_out,
  output logic [DROP_CNT_W-1:0]    dropped_reports_out
);

  localparam int WCW = $clog2(WINDOW_CYCLES);

  typedef struct packed {
    logic [DELTA_WIDTH-1:0]   delta;
    logic [COUNTER_WIDTH-1:0] total;
    logic [WIN_IDX_W-1:0]     window_idx;
  } rpt_t;

  mon_state_e               state_q, state_d;
  logic [WCW-1:0]           win_cnt_q, win_cnt_d;
  logic [COUNTER_WIDTH-1:0] base_q, base_d;
  logic [WIN_IDX_W-1:0]     idx_q, idx_d;
  logic                     alarm_q, alarm_d;
  logic [DROP_CNT_W-1:0]    drop_q, drop_d;
  logic                     capture, win_end, rpt_dropped;
  logic [COUNTER_WIDTH-1:0] raw;
  logic [DELTA_WIDTH-1:0]   delta;
  rpt_t                     rpt_new, rpt_out;

  always_ff @(posedge clk) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    capture = (state_q == INIT);
    win_end = (state_q == RUN) && (win_cnt_q == WCW'(WINDOW_CYCLES - 1));
  end

  // Modular subtraction absorbs upstream counter wrap-around.
  assign raw = race_count_in - base_q;

  if (COUNTER_WIDTH > DELTA_WIDTH) begin : g_sat
    assign delta = (|raw[COUNTER_WIDTH-1:DELTA_WIDTH]) ? '1 : raw[DELTA_WIDTH-1:0];
  end else begin : g_nosat
    assign delta = raw;
  end

  always_comb begin
    win_cnt_d = (capture || win_end) ? '0 : win_cnt_q + 1'b1;
    base_d    = (capture || win_end) ? race_count_in : base_q;
    idx_d     = win_end ? idx_q + 1'b1 : idx_q;
    alarm_d   = alarm_q;
    if (win_end && (delta > threshold_in)) alarm_d = 1'b1;
    else if (alarm_clear_in)               alarm_d = 1'b0;
    drop_d    = (rpt_dropped && (drop_q != '1)) ? drop_q + 1'b1 : drop_q;
    rpt_new   = '{delta: delta, total: race_count_in, window_idx: idx_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_q <= '0;
      base_q    <= '0;
      idx_q     <= '0;
      alarm_q   <= 1'b0;
      drop_q    <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      alarm_q   <= alarm_d;
      drop_q    <= drop_d;
    end
  end

  kanagawa_race_report_reg #(.rpt_t(rpt_t)) u_rpt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (win_end),
    .rpt_i     (rpt_new),
    .ready_i   (report_ready_in),
    .valid_o   (report_valid_out),
    .rpt_o     (rpt_out),
    .dropped_o (rpt_dropped)
  );

  assign report_delta_out      = rpt_out.delta;
  assign report_total_out      = rpt_out.total;
  assign report_window_idx_out = rpt_out.window_idx;
  assign alarm_out             = alarm_q;
  assign dropped_reports_out   = drop_q;

endmodule

// File: tb/tb_kanagawa_race_rate_monitor.sv
// Scoreboard bench for the race rate monitor: a window-level model queues the
// reports it expects; a monitor pops and compares on every handshake.
module tb_kanagawa_race_rate_monitor;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cnt_i = '0;
  logic [15:0] thr_i = '0;
  logic        clr_i = 1'b0;
  logic        rdy_i = 1'b1;
  logic        valid_o, alarm_o;
  logic [15:0] delta_o, idx_o;
  logic [31:0] total_o;
  logic [7:0]  drop_o;

  kanagawa_race_rate_monitor #(
    .COUNTER_WIDTH(32), .DELTA_WIDTH(16), .WINDOW_CYCLES(W)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .race_count_in         (cnt_i),
    .threshold_in          (thr_i),
    .alarm_clear_in        (clr_i),
    .report_valid_out      (valid_o),
    .report_ready_in       (rdy_i),
    .report_delta_out      (delta_o),
    .report_total_out      (total_o),
    .report_window_idx_out (idx_o),
    .alarm_out             (alarm_o),
    .dropped_reports_out   (drop_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [31:0] t;
    logic [15:0] i;
  } exp_t;

  exp_t        q[$];
  int          total = 0, bad = 0;
  int          e = 0, idx = 0, drop_nxt = 0, drop_exp = 0;
  logic [31:0] base = '0, c = '0;
  bit          alarm_nxt = 0, alarm_exp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One cycle: drive inputs at negedge, then advance the model to what the
  // coming rising edge will produce. Edge e counts from INIT (e=0).
  task automatic step(input logic [31:0] cv, input logic [15:0] th, input bit cl,
                      input bit rd, input bit r);
    logic [31:0] raw;
    exp_t        x;
    @(negedge clk);
    alarm_exp = alarm_nxt;
    drop_exp  = drop_nxt;
    cnt_i = cv; thr_i = th; clr_i = cl; rdy_i = rd; rst = r;
    if (r) begin
      q.delete();
      e = 0; idx = 0; base = '0; alarm_nxt = 0; drop_nxt = 0;
    end else begin
      if (e > 0 && e % W == 0) begin
        raw = cv - base;
        x.d = (raw > 32'h0000_FFFF) ? 16'hFFFF : raw[15:0];
        x.t = cv;
        x.i = idx[15:0];
        base = cv;
        if (x.d > th) alarm_nxt = 1;
        else if (cl)  alarm_nxt = 0;
        if (q.size() != 0 && !rd) drop_nxt = (drop_nxt < 255) ? drop_nxt + 1 : 255;
        else                      q.push_back(x);
        idx = (idx + 1) % 65536;
      end else begin
        if (e == 0) base = cv;
        if (cl) alarm_nxt = 0;
      end
      e++;
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      chk("alarm", 64'(alarm_o), 64'(alarm_exp));
      chk("dropped", 64'(drop_o), 64'(drop_exp));
      if (valid_o) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 64'(valid_o), 64'd0);
        end else begin
          chk("delta", 64'(delta_o), 64'(q[0].d));
          chk("total", 64'(total_o), 64'(q[0].t));
          chk("idx", 64'(idx_o), 64'(q[0].i));
          if (rdy_i) void'(q.pop_front());
        end
      end
    end
  end

  task automatic chk_reset_outputs();
    #2;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_delta", 64'(delta_o), 64'd0);
    chk("rst_total", 64'(total_o), 64'd0);
    chk("rst_idx", 64'(idx_o), 64'd0);
    chk("rst_alarm", 64'(alarm_o), 64'd0);
    chk("rst_drop", 64'(drop_o), 64'd0);
  endtask

  initial begin
    repeat (3) step(32'd0, 16'd0, 0, 1, 1);
    chk_reset_outputs();

    // Idle counter: zero deltas, strict compare against threshold 0.
    for (int k = 0; k < 2*W + 4; k++) step(32'd0, 16'd0, 0, 1, 0);

    // Exceed threshold 2, mid-window clear, then clear coinciding with a set.
    repeat (2) step(32'd0, 16'd2, 0, 1, 1);
    for (int k = 0; k < 3*W + 2; k++)
      step(32'(k / 3), 16'd2, (k == W + 4) || (k == 2*W), 1, 0);

    // Counter wrap across the window, then a saturating jump.
    repeat (2) step(32'd0, 16'hFFFF, 0, 1, 1);
    step(32'hFFFF_FFFE, 16'hFFFF, 0, 1, 0);
    for (int k = 1; k < W; k++) step(32'hFFFF_FFFF, 16'hFFFF, 0, 1, 0);
    step(32'h0000_0003, 16'hFFFF, 0, 1, 0);
    c = 32'd3;
    for (int k = 0; k < 2*W; k++) begin
      if (k == 5) c = c + 32'd70000;
      step(c, 16'hFFF0, 0, 1, 0);
    end

    // Backpressure over three windows, then release.
    repeat (2) step(32'd0, 16'hFFFF, 0, 1, 1);
    c = 32'd100;
    for (int k = 0; k <= 3*W + 2; k++) begin
      c = c + 32'(k % 2);
      step(c, 16'hFFFF, 0, 0, 0);
    end
    for (int k = 0; k < 2*W; k++) begin
      c = c + 32'd1;
      step(c, 16'hFFFF, 0, 1, 0);
    end

    // Reset mid-window with a report pending, then restart from a new base.
    for (int k = 0; k < W + 6; k++) begin
      c = c + 32'd2;
      step(c, 16'hFFFF, 0, 0, 0);
    end
    step(c, 16'hFFFF, 0, 0, 1);
    step(c, 16'hFFFF, 0, 0, 1);
    chk_reset_outputs();
    c = 32'h1234_5678;
    for (int k = 0; k < 2*W + 2; k++) begin
      c = c + 32'd3;
      step(c, 16'hFFFF, 0, 1, 0);
    end

    // Randomized traffic with occasional backpressure, clears and resets.
    for (int k = 0; k < 1500; k++) begin
      c = c + ($urandom_range(0, 99) == 0 ? 32'($urandom_range(60000, 80000))
                                          : 32'($urandom_range(0, 3)));
      step(c, 16'($urandom_range(18, 30)), $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 599) == 0);
    end

    // Drain: every expected report must have been delivered.
    for (int k = 0; k < 3*W && !(e % W == 3 && e > W); k++) step(c, 16'hFFFF, 0, 1, 0);
    #2;
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
